// File: rtl/rf_write_queue.sv
// -----------------------------------------------------------------------------
// rf_write_queue
//   In-order write buffer in front of the register file's single write port.
//   Writeback sources push (addr, data) pairs through a valid/ready handshake.
//   The oldest entry is drained into the register file whenever the write port
//   is granted. Two combinational forwarding lookups let readers see values
//   that are still pending and not yet written.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   push handshake; req_ready depends only on state
//   req_addr, req_data    destination register and value; addr 0 is dropped
//   drain_enable          write port granted this cycle
//   rf_write_*            head entry presented to the register file
//   lookup_addr1/2        forwarding queries
//   fwd_hit1/2, fwd_data1/2  youngest pending match per query (0 on miss)
//   pending_count, empty  occupancy
// -----------------------------------------------------------------------------
module rf_write_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_addr,
  input  logic [31:0]      req_data,
  input  logic             drain_enable,
  output logic [4:0]       rf_write_addr,
  output logic [31:0]      rf_write_data,
  output logic             rf_write_enable,
  input  logic [4:0]       lookup_addr1,
  input  logic [4:0]       lookup_addr2,
  output logic             fwd_hit1,
  output logic [31:0]      fwd_data1,
  output logic             fwd_hit2,
  output logic [31:0]      fwd_data2,
  output logic [CNT_W-1:0] pending_count,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push_s;   // handshake this cycle
  logic store_s;  // handshake that actually creates an entry
  logic pop_s;    // head written to the register file this cycle

  // Handshake, drain and head presentation
  always_comb begin
    empty           = (count_q == {CNT_W{1'b0}});
    req_ready       = (count_q != CNT_W'(DEPTH));
    push_s          = req_valid && req_ready;
    // Writes to r0 are architecturally discarded: accept but do not store.
    store_s         = push_s && (req_addr != 5'd0);
    pop_s           = !empty && drain_enable;
    rf_write_enable = pop_s;
    pending_count   = count_q;
    if (!empty) begin
      rf_write_addr = addr_q[rd_ptr_q];
      rf_write_data = data_q[rd_ptr_q];
    end else begin
      rf_write_addr = 5'd0;
      rf_write_data = 32'd0;
    end
  end

  // Pointer and occupancy next-state
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (store_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    case ({store_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards all pending entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed through count-qualified slots
  always_ff @(posedge clk) begin
    if (store_s) begin
      addr_q[wr_ptr_q] <= req_addr;
      data_q[wr_ptr_q] <= req_data;
    end
  end

  // Forwarding: walk valid entries oldest to youngest so the last match wins
  always_comb begin
    logic [PTR_W-1:0] slot_v;
    fwd_hit1  = 1'b0;
    fwd_data1 = 32'd0;
    fwd_hit2  = 1'b0;
    fwd_data2 = 32'd0;
    slot_v    = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      slot_v = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if ((lookup_addr1 != 5'd0) && (addr_q[slot_v] == lookup_addr1)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = data_q[slot_v];
        end else begin
          fwd_hit1  = fwd_hit1;
        end
        if ((lookup_addr2 != 5'd0) && (addr_q[slot_v] == lookup_addr2)) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = data_q[slot_v];
        end else begin
          fwd_hit2  = fwd_hit2;
        end
      end else begin
        slot_v = slot_v;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_queue.sv
module tb_rf_write_queue;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_addr;
  logic [31:0] req_data;
  logic        drain_enable;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic        rf_write_enable;
  logic [4:0]  lookup_addr1;
  logic [4:0]  lookup_addr2;
  logic        fwd_hit1;
  logic [31:0] fwd_data1;
  logic        fwd_hit2;
  logic [31:0] fwd_data2;
  logic [2:0]  pending_count;
  logic        empty;

  int errors;
  int checks;

  logic [4:0]  log_addr[$];
  logic [31:0] log_data[$];

  rf_write_queue #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .drain_enable(drain_enable),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .rf_write_enable(rf_write_enable),
    .lookup_addr1(lookup_addr1), .lookup_addr2(lookup_addr2),
    .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .pending_count(pending_count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: record every write the DUT issues
  always @(posedge clk) begin
    if (rf_write_enable) begin
      log_addr.push_back(rf_write_addr);
      log_data.push_back(rf_write_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic test_reset();
    #3;
    checks++; if (pending_count !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", pending_count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%b exp=1", empty); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    checks++; if ({rf_write_enable, rf_write_addr, rf_write_data} !== 38'd0) begin errors++; $display("FAIL rst_rf got=%b/%h/%h exp=0/00/00000000", rf_write_enable, rf_write_addr, rf_write_data); end
    checks++; if ({fwd_hit1, fwd_data1, fwd_hit2, fwd_data2} !== 66'd0) begin errors++; $display("FAIL rst_fwd got=%b/%h/%b/%h exp=0", fwd_hit1, fwd_data1, fwd_hit2, fwd_data2); end
    step();
    rst_n = 1'b1;
    drain_enable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (empty !== 1'b1 || req_ready !== 1'b1 || rf_write_enable !== 1'b0) begin
        errors++;
        $display("FAIL idle_cycle%0d got empty=%b ready=%b we=%b exp 1/1/0", c, empty, req_ready, rf_write_enable);
      end
    end
  endtask

  task automatic test_fill_drain();
    logic [4:0]  ea [5];
    logic [31:0] ed [5];
    ea = '{5'd5, 5'd6, 5'd7, 5'd8, 5'd9};
    ed = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h99999999};
    drain_enable = 1'b0;
    clear_log();
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'b1; req_addr = ea[k]; req_data = ed[k];
      step();
    end
    checks++; if (pending_count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", pending_count); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", req_ready); end
    req_addr = ea[4]; req_data = ed[4];
    step();
    checks++; if (pending_count !== 3'd4) begin errors++; $display("FAIL held_count got=%0d exp=4", pending_count); end
    drain_enable = 1'b1;
    #1;
    checks++; if (rf_write_enable !== 1'b1 || rf_write_addr !== 5'd5 || rf_write_data !== 32'h11111111) begin errors++; $display("FAIL head_out got=%b/%0d/%h exp=1/5/11111111", rf_write_enable, rf_write_addr, rf_write_data); end
    step();
    // No full-bypass: r9 must not have entered on the first pop edge
    checks++; if (pending_count !== 3'd3 || req_ready !== 1'b1) begin errors++; $display("FAIL pop1 got count=%0d ready=%b exp 3/1", pending_count, req_ready); end
    step();
    req_valid = 1'b0;
    checks++; if (pending_count !== 3'd3) begin errors++; $display("FAIL pop2_push got=%0d exp=3", pending_count); end
    for (int c = 0; c < 3; c++) step();
    checks++; if (pending_count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL drained got count=%0d empty=%b exp 0/1", pending_count, empty); end
    checks++; if (log_addr.size() != 5) begin errors++; $display("FAIL fill_log_size got=%0d exp=5", log_addr.size()); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= log_addr.size() || log_addr[k] !== ea[k] || log_data[k] !== ed[k]) begin
        errors++;
        $display("FAIL fill_order%0d exp=%0d/%h", k, ea[k], ed[k]);
      end
    end
  endtask

  task automatic test_latency();
    drain_enable = 1'b1;
    clear_log();
    req_valid = 1'b1; req_addr = 5'd10; req_data = 32'hA0A0A0A0;
    step();
    req_valid = 1'b0;
    checks++; if (pending_count !== 3'd1 || rf_write_enable !== 1'b1 || rf_write_addr !== 5'd10) begin errors++; $display("FAIL lat_head got count=%0d we=%b addr=%0d exp 1/1/10", pending_count, rf_write_enable, rf_write_addr); end
    step();
    checks++; if (log_addr.size() != 1 || log_data[0] !== 32'hA0A0A0A0) begin errors++; $display("FAIL lat_write got size=%0d exp 1 write of a0a0a0a0", log_addr.size()); end
  endtask

  task automatic test_forward();
    drain_enable = 1'b0;
    clear_log();
    req_valid = 1'b1; req_addr = 5'd3; req_data = 32'hAAAA0000;
    step();
    req_data = 32'hBBBB0000;
    step();
    req_valid = 1'b0;
    lookup_addr1 = 5'd3; lookup_addr2 = 5'd4;
    #1;
    checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'hBBBB0000) begin errors++; $display("FAIL fwd_youngest got=%b/%h exp=1/bbbb0000", fwd_hit1, fwd_data1); end
    checks++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 32'd0) begin errors++; $display("FAIL fwd_miss got=%b/%h exp=0/00000000", fwd_hit2, fwd_data2); end
    req_valid = 1'b1; req_addr = 5'd12; req_data = 32'hCCCC1234; lookup_addr1 = 5'd12;
    #1;
    checks++; if (fwd_hit1 !== 1'b0) begin errors++; $display("FAIL fwd_same_cycle got=%b exp=0", fwd_hit1); end
    step();
    req_valid = 1'b0;
    checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'hCCCC1234) begin errors++; $display("FAIL fwd_after_edge got=%b/%h exp=1/cccc1234", fwd_hit1, fwd_data1); end
    drain_enable = 1'b1;
    step();
    lookup_addr1 = 5'd3;
    #1;
    checks++; if (rf_write_enable !== 1'b1 || fwd_hit1 !== 1'b1 || fwd_data1 !== 32'hBBBB0000) begin errors++; $display("FAIL fwd_head_draining got we=%b hit=%b data=%h exp 1/1/bbbb0000", rf_write_enable, fwd_hit1, fwd_data1); end
    step();
    step();
    checks++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== 32'd0) begin errors++; $display("FAIL fwd_empty got=%b/%h exp=0/00000000", fwd_hit1, fwd_data1); end
    checks++;
    if (log_addr.size() != 3 || log_data[0] !== 32'hAAAA0000 || log_data[1] !== 32'hBBBB0000 || log_addr[2] !== 5'd12) begin
      errors++; $display("FAIL fwd_write_order got size=%0d exp r3:aaaa0000,r3:bbbb0000,r12", log_addr.size());
    end
    lookup_addr1 = 5'd0; lookup_addr2 = 5'd0;
  endtask

  task automatic test_zero_addr();
    drain_enable = 1'b0;
    clear_log();
    req_valid = 1'b1; req_addr = 5'd0; req_data = 32'hDEADBEEF;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got=%b exp=1", req_ready); end
    step();
    req_valid = 1'b0;
    lookup_addr1 = 5'd0;
    checks++; if (pending_count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL r0_count got=%0d empty=%b exp 0/1", pending_count, empty); end
    checks++; if (fwd_hit1 !== 1'b0) begin errors++; $display("FAIL r0_fwd got=%b exp=0", fwd_hit1); end
    drain_enable = 1'b1;
    for (int c = 0; c < 3; c++) step();
    checks++; if (log_addr.size() != 0) begin errors++; $display("FAIL r0_no_write got=%0d writes exp=0", log_addr.size()); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  ea [6];
    logic [31:0] ed [6];
    ea = '{5'd1, 5'd2, 5'd11, 5'd12, 5'd13, 5'd14};
    ed = '{32'h00000101, 32'h00000202, 32'h00000B0B, 32'h00000C0C, 32'h00000D0D, 32'h00000E0E};
    drain_enable = 1'b0;
    clear_log();
    for (int k = 0; k < 2; k++) begin
      req_valid = 1'b1; req_addr = ea[k]; req_data = ed[k];
      step();
    end
    drain_enable = 1'b1;
    for (int k = 2; k < 6; k++) begin
      req_addr = ea[k]; req_data = ed[k];
      step();
      checks++; if (pending_count !== 3'd2) begin errors++; $display("FAIL b2b_count%0d got=%0d exp=2", k, pending_count); end
    end
    req_valid = 1'b0;
    step();
    step();
    checks++; if (log_addr.size() != 6) begin errors++; $display("FAIL b2b_log_size got=%0d exp=6", log_addr.size()); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k >= log_addr.size() || log_addr[k] !== ea[k] || log_data[k] !== ed[k]) begin
        errors++;
        $display("FAIL b2b_order%0d exp=%0d/%h", k, ea[k], ed[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    drain_enable = 1'b0;
    clear_log();
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_addr = 5'(20 + k); req_data = 32'h5000 + k;
      step();
    end
    req_valid = 1'b0;
    checks++; if (pending_count !== 3'd3) begin errors++; $display("FAIL mid_pre_count got=%0d exp=3", pending_count); end
    drain_enable = 1'b1;
    lookup_addr1 = 5'd20;
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (pending_count !== 3'd0 || rf_write_enable !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL mid_rst got count=%0d we=%b empty=%b exp 0/0/1", pending_count, rf_write_enable, empty); end
    checks++; if (fwd_hit1 !== 1'b0 || rf_write_addr !== 5'd0 || rf_write_data !== 32'd0) begin errors++; $display("FAIL mid_rst_out got hit=%b addr=%0d data=%h exp 0/0/0", fwd_hit1, rf_write_addr, rf_write_data); end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) step();
    checks++; if (log_addr.size() != 0) begin errors++; $display("FAIL mid_discard got=%0d writes exp=0", log_addr.size()); end
    checks++; if (pending_count !== 3'd0 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_after got count=%0d ready=%b exp 0/1", pending_count, req_ready); end
    lookup_addr1 = 5'd0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_addr = 5'd0;
    req_data = 32'd0;
    drain_enable = 1'b0;
    lookup_addr1 = 5'd0;
    lookup_addr2 = 5'd0;
    test_reset();
    test_fill_drain();
    test_latency();
    test_forward();
    test_zero_addr();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_write_queue.md
Name: rf_write_queue

Overview:
- Writer-side front end for the register file's single write port. Accepts register-write requests from writeback sources (ALU, load, MDU) through a valid/ready handshake.
- Buffers requests in order in a small FIFO. Drains one entry per cycle into the register file when the port is granted.
- Provides two forwarding lookups so decode-stage readers see values that are still pending and not yet written.

Parameters:
DEPTH, 4, number of queue entries; power of two, range 2..16
CNT_W, 3, width of pending_count; must equal log2(DEPTH)+1

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  write request present
req_ready  out  1  queue can accept a request this cycle
req_addr  in  5  destination register number
req_data  in  32  value to write
drain_enable  in  1  register file write port granted to this block this cycle
rf_write_addr  out  5  to register file write_addr
rf_write_data  out  32  to register file write_data
rf_write_enable  out  1  to register file write_enable; 1 = write
lookup_addr1  in  5  forwarding query 1 (read port 1 address)
lookup_addr2  in  5  forwarding query 2 (read port 2 address)
fwd_hit1  out  1  a pending entry matches lookup_addr1
fwd_data1  out  32  data of the youngest matching entry for query 1
fwd_hit2  out  1  a pending entry matches lookup_addr2
fwd_data2  out  32  data of the youngest matching entry for query 2
pending_count  out  CNT_W  number of valid entries
empty  out  1  pending_count == 0

Behaviour:
Reset:
- rst_n low clears all entries immediately, without waiting for a clock edge.
- While in reset and after release: pending_count=0, empty=1, req_ready=1, rf_write_enable=0, rf_write_addr=0, rf_write_data=0, fwd_hit*=0, fwd_data*=0.
- Reset mid-operation discards every pending write; nothing is written to the register file afterwards.

Accept (push):
- A handshake occurs when req_valid && req_ready at a rising edge.
- req_ready = (pending_count != DEPTH). It is registered-state only, with no combinational dependence on drain_enable or req_valid.
- If req_addr == 0, the request is accepted and dropped. No entry is created and the count is unchanged.

Drain (pop):
- rf_write_enable = !empty && drain_enable.
- rf_write_addr/rf_write_data show the head (oldest) entry combinationally whenever !empty, and are 0 when empty.
- The head is popped at the rising edge where rf_write_enable=1; the register file captures it on the same edge.
- Latency when drain_enable is held high: a request accepted at edge N is written to the register file at edge N+1.

Simultaneous push and pop:
- Both occur on the same edge; count is unchanged and order is preserved.
- When full, req_ready=0 even if a pop is happening that cycle (no full-bypass).

Ordering and pointers:
- Strict FIFO order, including multiple writes to the same register; the last accepted write wins in the register file.
- Read/write pointers wrap modulo DEPTH.
- pending_count ranges 0..DEPTH and never overflows or underflows.

Forwarding:
- Purely combinational over the valid entries only.
- hit = any valid entry with addr == lookup_addr. data = the youngest such entry; if no hit, data = 0.
- lookup_addr == 0 never hits.
- The head entry being drained this cycle still hits.
- A request being accepted in the same cycle is not visible until after the edge.

Test Plan:
1. Reset, then drain_enable=1 with no requests -> empty=1, req_ready=1, rf_write_enable=0 for 10 cycles.
2. drain_enable=0; push (r5,0x11111111), (r6,0x22222222), (r7,0x33333333), (r8,0x44444444) -> pending_count=4, req_ready=0. A fifth request (r9) is held, not accepted. Then drain_enable=1 -> writes occur on 4 consecutive edges in order r5, r6, r7, r8; r9 is accepted on the first pop edge plus one.
3. drain_enable=0; push (r3,0xAAAA0000) then (r3,0xBBBB0000); lookup_addr1=3 -> fwd_hit1=1, fwd_data1=0xBBBB0000. lookup_addr2=4 -> fwd_hit2=0, fwd_data2=0.
4. Push (r0,0xDEADBEEF) -> accepted with req_ready=1; pending_count stays 0; lookup_addr1=0 gives fwd_hit1=0; no register file write is ever issued.
5. Queue holding 2 entries with drain_enable=1 and req_valid=1 every cycle -> pending_count stays 2 and the write sequence matches push order exactly.
6. Queue holding 3 entries; assert rst_n=0 between clock edges -> pending_count=0 and rf_write_enable=0 immediately. After release, no write occurs for the discarded entries.
